ray_column_scheduler: RTL and testbench

RAY_COLUMN_SCHEDULER -- requirements
Module: ray_column_scheduler

---
 rtl/ray_pkg.sv | 28 ++
 rtl/ray_column_scheduler_if.sv | 35 +++
 rtl/ray_dir_unit.sv | 23 ++
 rtl/ray_column_scheduler.sv | 153 +++++++++++++++
 tb/tb_ray_column_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_pkg.sv
// Shared types and constants for the ray column scheduler: Q8.8 scalar type,
// screen/camera constants and the scheduler state encoding.
package ray_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam int unsigned SCREEN_WIDTH = 320;
  localparam int unsigned CAM_STEP     = 410;
  localparam logic [15:0] DELTA_SAT    = 16'h7FFF;

  // Camera accumulator is Q8.16; column 0 sits at -1.0.
  localparam logic signed [23:0] CAM_START = -24'sd65536;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StDivxGo,
    StDivxWait,
    StDivyGo,
    StDivyWait,
    StEmit
  } sched_state_e;

  function automatic logic [15:0] abs_q8_8(input q8_8_t v);
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

endpackage

// File: rtl/ray_column_scheduler_if.sv
// Divider and DDA-side signal bundle of the ray column scheduler, with the
// scheduler (master) and consumer (slave) views.
interface ray_column_scheduler_if;

  logic        div_start;
  logic [15:0] div_b;
  logic        div_busy;
  logic        div_done;
  logic        div_dbz;
  logic [31:0] div_val;

  logic        ray_valid;
  logic        ray_ready;
  logic [8:0]  hcount;
  logic [31:0] pos;
  logic [15:0] ray_dir_x;
  logic [15:0] ray_dir_y;
  logic [15:0] delta_x;
  logic [15:0] delta_y;

  modport master (
    output div_start, div_b,
    input  div_busy, div_done, div_dbz, div_val,
    output ray_valid, hcount, pos, ray_dir_x, ray_dir_y, delta_x, delta_y,
    input  ray_ready
  );

  modport slave (
    input  div_start, div_b,
    output div_busy, div_done, div_dbz, div_val,
    input  ray_valid, hcount, pos, ray_dir_x, ray_dir_y, delta_x, delta_y,
    output ray_ready
  );

endinterface

// File: rtl/ray_dir_unit.sv
// Per-column ray direction: rayDir = dir + ((plane * cameraX) >>> 8) on each axis,
// using a 32-bit signed product truncated back to Q8.8.
module ray_dir_unit
  import ray_pkg::*;
(
  input  q8_8_t dir_x_i,
  input  q8_8_t dir_y_i,
  input  q8_8_t plane_x_i,
  input  q8_8_t plane_y_i,
  input  q8_8_t camera_x_i,
  output q8_8_t ray_dir_x_o,
  output q8_8_t ray_dir_y_o
);

  logic signed [31:0] prod_x, prod_y;

  assign prod_x = 32'(plane_x_i) * 32'(camera_x_i);
  assign prod_y = 32'(plane_y_i) * 32'(camera_x_i);

  assign ray_dir_x_o = dir_x_i + q8_8_t'(prod_x >>> 8);
  assign ray_dir_y_o = dir_y_i + q8_8_t'(prod_y >>> 8);

endmodule

// File: rtl/ray_column_scheduler.sv
// Walks the 320 screen columns of a frame: computes each ray direction, runs two
// reciprocal divisions on an external divider and hands the ray to the DDA stage.
module ray_column_scheduler
  import ray_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  output logic        busy_out,
  output logic        frame_done_out,
  input  logic [31:0] pos_in,
  input  logic [31:0] dir_in,
  input  logic [31:0] plane_in,
  output logic        div_start_out,
  output logic [15:0] div_b_out,
  input  logic        div_busy_in,
  input  logic        div_done_in,
  input  logic        div_dbz_in,
  input  logic [31:0] div_val_in,
  output logic        ray_valid_out,
  input  logic        ray_ready_in,
  output logic [8:0]  hcount_out,
  output logic [31:0] pos_out,
  output logic [15:0] rayDirX_out,
  output logic [15:0] rayDirY_out,
  output logic [15:0] deltaDistX_out,
  output logic [15:0] deltaDistY_out
);

  sched_state_e       state_q;
  logic [31:0]        pos_q, dir_q, plane_q;
  logic signed [23:0] cam_acc_q;
  logic [8:0]         col_q;
  q8_8_t              ray_x_q, ray_y_q, ray_dir_x, ray_dir_y;
  logic [15:0]        delta_x_q, delta_y_q, div_b_q, div_result;
  logic               div_start_q, valid_q, done_q, busy_q;
  logic               last_col;

  ray_dir_unit u_ray_dir (
    .dir_x_i    (q8_8_t'(dir_q[31:16])),
    .dir_y_i    (q8_8_t'(dir_q[15:0])),
    .plane_x_i  (q8_8_t'(plane_q[31:16])),
    .plane_y_i  (q8_8_t'(plane_q[15:0])),
    .camera_x_i (q8_8_t'(cam_acc_q[23:8])),
    .ray_dir_x_o(ray_dir_x),
    .ray_dir_y_o(ray_dir_y)
  );

  // Quotients that do not fit a positive Q8.8 (or divide-by-zero) saturate.
  assign div_result = (div_dbz_in || (|div_val_in[31:15])) ? DELTA_SAT : div_val_in[15:0];
  assign last_col   = (col_q == 9'(SCREEN_WIDTH - 1));

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      dir_q       <= '0;
      plane_q     <= '0;
      cam_acc_q   <= '0;
      col_q       <= '0;
      ray_x_q     <= '0;
      ray_y_q     <= '0;
      delta_x_q   <= '0;
      delta_y_q   <= '0;
      div_b_q     <= '0;
      div_start_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start_in) begin
            pos_q     <= pos_in;
            dir_q     <= dir_in;
            plane_q   <= plane_in;
            cam_acc_q <= CAM_START;
            col_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          ray_x_q     <= ray_dir_x;
          ray_y_q     <= ray_dir_y;
          div_b_q     <= abs_q8_8(ray_dir_x);
          div_start_q <= !div_busy_in;
          state_q     <= StDivxGo;
        end
        // The start pulse is raised only from a cycle that saw the divider idle.
        StDivxGo: begin
          if (div_start_q) begin
            state_q <= StDivxWait;
          end else if (!div_busy_in) begin
            div_start_q <= 1'b1;
          end
        end
        StDivxWait: begin
          if (div_done_in) begin
            delta_x_q   <= div_result;
            div_b_q     <= abs_q8_8(ray_y_q);
            div_start_q <= !div_busy_in;
            state_q     <= StDivyGo;
          end
        end
        StDivyGo: begin
          if (div_start_q) begin
            state_q <= StDivyWait;
          end else if (!div_busy_in) begin
            div_start_q <= 1'b1;
          end
        end
        StDivyWait: begin
          if (div_done_in) begin
            delta_y_q <= div_result;
            valid_q   <= 1'b1;
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (ray_ready_in) begin
            valid_q <= 1'b0;
            if (last_col) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              col_q     <= col_q + 9'd1;
              cam_acc_q <= cam_acc_q + 24'(CAM_STEP);
              state_q   <= StSetup;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign div_start_out  = div_start_q;
  assign div_b_out      = div_b_q;
  assign ray_valid_out  = valid_q;
  assign hcount_out     = col_q;
  assign pos_out        = pos_q;
  assign rayDirX_out    = ray_x_q;
  assign rayDirY_out    = ray_y_q;
  assign deltaDistX_out = delta_x_q;
  assign deltaDistY_out = delta_y_q;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Scoreboard bench for ray_column_scheduler: a reference model pushes every column's
// expected ray, a monitor pops on each valid/ready transfer; a divider model answers starts.
module tb_ray_column_scheduler;
  import ray_pkg::*;

  typedef struct {
    logic [8:0]  h;
    logic [31:0] pos;
    logic [15:0] rx, ry, dx, dy;
  } ray_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        busy, frame_done;
  logic [31:0] pos_in = '0, dir_in = '0, plane_in = '0;

  ray_column_scheduler_if bus ();

  ray_column_scheduler dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .frame_start_in(frame_start),
    .busy_out      (busy),
    .frame_done_out(frame_done),
    .pos_in        (pos_in),
    .dir_in        (dir_in),
    .plane_in      (plane_in),
    .div_start_out (bus.div_start),
    .div_b_out     (bus.div_b),
    .div_busy_in   (bus.div_busy),
    .div_done_in   (bus.div_done),
    .div_dbz_in    (bus.div_dbz),
    .div_val_in    (bus.div_val),
    .ray_valid_out (bus.ray_valid),
    .ray_ready_in  (bus.ray_ready),
    .hcount_out    (bus.hcount),
    .pos_out       (bus.pos),
    .rayDirX_out   (bus.ray_dir_x),
    .rayDirY_out   (bus.ray_dir_y),
    .deltaDistX_out(bus.delta_x),
    .deltaDistY_out(bus.delta_y)
  );

  initial forever #5 clk = ~clk;

  int   tests = 0, fails = 0, xfers = 0, starts = 0, busy_hits = 0;
  int   lat_fixed = 0, busy_col = -1, hold_col = -1;
  bit   held = 0, stray_req = 0;
  ray_t exp_q[$];
  ray_t got0, got160;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] delta_of(input logic [15:0] r);
    int m, q;
    m = int'($signed(r));
    if (m < 0) m = -m;
    if (m == 0) return 16'h7FFF;
    q = 65536 / m;
    if (q >= 32768) return 16'h7FFF;
    return q[15:0];
  endfunction

  // Reference: column c uses cameraX = floor((-1.0 + c*410/65536) * 256).
  function automatic void push_frame(input logic [31:0] p, input logic [31:0] d,
                                     input logic [31:0] pl);
    for (int c = 0; c < 320; c++) begin
      int   cam, rx, ry;
      ray_t e;
      cam   = (-65536 + 410 * c) >>> 8;
      rx    = int'($signed(d[31:16])) + ((int'($signed(pl[31:16])) * cam) >>> 8);
      ry    = int'($signed(d[15:0])) + ((int'($signed(pl[15:0])) * cam) >>> 8);
      e.h   = 9'(c);
      e.pos = p;
      e.rx  = rx[15:0];
      e.ry  = ry[15:0];
      e.dx  = delta_of(e.rx);
      e.dy  = delta_of(e.ry);
      exp_q.push_back(e);
    end
  endfunction

  // Divider: answers each start after a latency, optionally stays busy after an X result.
  initial begin
    int          cnt = 0, bcnt = 0, col = 0;
    logic [15:0] b = '0;
    bit          is_y = 0, parity = 0;
    bus.div_busy = 1'b0;
    bus.div_done = 1'b0;
    bus.div_dbz  = 1'b0;
    bus.div_val  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_done = 1'b0;
      bus.div_dbz  = 1'b0;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) bus.div_busy = 1'b0;
      end
      if (rst) begin
        cnt    = 0;
        parity = 0;
      end
      if (stray_req) begin
        stray_req    = 0;
        bus.div_done = 1'b1;
        bus.div_val  = 32'h100;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.div_done = 1'b1;
          bus.div_dbz  = (b == 0);
          bus.div_val  = (b == 0) ? 32'hDEAD_BEEF : 32'(65536 / int'(b));
          if (!is_y && col == busy_col) begin
            bus.div_busy = 1'b1;
            bcnt         = 5;
            busy_hits++;
          end
        end
      end
      if (bus.div_start && !rst) begin
        b      = bus.div_b;
        is_y   = parity;
        parity = !parity;
        col    = int'(bus.hcount);
        cnt    = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
    end
  end

  // DDA side: random backpressure, plus a 10-cycle stall on hold_col.
  initial begin
    int hold = 0;
    bus.ray_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        hold--;
        bus.ray_ready = 1'b0;
      end else if (bus.ray_valid && int'(bus.hcount) == hold_col && !held) begin
        held          = 1;
        hold          = 9;
        bus.ray_ready = 1'b0;
      end else begin
        bus.ray_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [127:0] snap, prev_snap;
    bit           prev_stall = 0, prev_start = 0, done_due = 0;
    ray_t         e, a;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 0;
        prev_start = 0;
        done_due   = 0;
        continue;
      end
      snap = 128'({bus.ray_valid, bus.hcount, bus.pos, bus.ray_dir_x, bus.ray_dir_y,
                   bus.delta_x, bus.delta_y});
      if (prev_stall) check("stall_hold", snap, prev_snap);
      if (bus.div_start) begin
        starts++;
        check("start_vs_busy", 128'(bus.div_busy), 0);
        check("start_width", 128'(prev_start), 0);
        check("start_in_emit", 128'(bus.ray_valid), 0);
      end
      if (done_due || frame_done) begin
        check("frame_done_pulse", 128'(frame_done), 128'(done_due));
        if (done_due) check("busy_after_done", 128'(busy), 0);
      end
      done_due = 0;
      if (bus.ray_valid && bus.ray_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("ray_expected", 128'(exp_q.size()), 1);
        end else begin
          e     = exp_q.pop_front();
          a.h   = bus.hcount;
          a.pos = bus.pos;
          a.rx  = bus.ray_dir_x;
          a.ry  = bus.ray_dir_y;
          a.dx  = bus.delta_x;
          a.dy  = bus.delta_y;
          check("hcount", 128'(a.h), 128'(e.h));
          check("pos", 128'(a.pos), 128'(e.pos));
          check("rayDirX", 128'(a.rx), 128'(e.rx));
          check("rayDirY", 128'(a.ry), 128'(e.ry));
          check("deltaDistX", 128'(a.dx), 128'(e.dx));
          check("deltaDistY", 128'(a.dy), 128'(e.dy));
          if (a.h == 9'd0) got0 = a;
          if (a.h == 9'd160) got160 = a;
          if (e.h == 9'd319) done_due = 1;
        end
      end
      prev_stall = bus.ray_valid && !bus.ray_ready;
      prev_snap  = snap;
      prev_start = bus.div_start;
    end
  end

  function automatic logic [127:0] all_outputs();
    return 128'({busy, frame_done, bus.div_start, bus.div_b, bus.ray_valid, bus.hcount,
                 bus.pos, bus.ray_dir_x, bus.ray_dir_y, bus.delta_x, bus.delta_y});
  endfunction

  task automatic run_frame(input logic [31:0] p, input logic [31:0] d, input logic [31:0] pl,
                           input int ignore_col, input int lat);
    int n;
    bit ok;
    lat_fixed = lat;
    xfers     = 0;
    starts    = 0;
    pos_in    = p;
    dir_in    = d;
    plane_in  = pl;
    push_frame(p, d, pl);
    @(posedge clk);
    #1 frame_start = 1'b1;
    n  = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 frame_start = 1'b0;
      n++;
      if (bus.ray_valid) begin
        ok = 1;
        break;
      end
    end
    check("first_valid_seen", 128'(ok), 1);
    if (lat > 0) check("column_latency", 128'(n), 128'(4 + 2 * lat));
    if (ignore_col >= 0) begin
      ok = 0;
      for (int i = 0; i < 20000; i++) begin
        if (bus.ray_valid && int'(bus.hcount) == ignore_col) begin
          ok = 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("ignore_col_reached", 128'(ok), 1);
      frame_start = 1'b1;
      pos_in      = $urandom;
      dir_in      = $urandom;
      plane_in    = $urandom;
      @(posedge clk);
      #1 frame_start = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 30000; i++) begin
      if (frame_done) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("frame_done_seen", 128'(ok), 1);
    @(negedge clk);
    check("frame_xfers", 128'(xfers), 320);
    check("frame_div_starts", 128'(starts), 640);
    check("busy_after_frame", 128'(busy), 0);
    check("hcount_hold_319", 128'(bus.hcount), 319);
    check("queue_drained", 128'(exp_q.size()), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Frame 1: reference camera, stall at column 5, busy divider at column 7.
    hold_col = 5;
    held     = 0;
    busy_col = 7;
    run_frame($urandom, 32'h0100_0000, 32'h0000_00A9, 100, 0);
    check("col0_hcount", 128'(got0.h), 0);
    check("col0_rayDirX", 128'(got0.rx), 128'(16'h0100));
    check("col0_rayDirY", 128'(got0.ry), 128'(16'hFF57));
    check("col0_deltaDistX", 128'(got0.dx), 128'(16'h0100));
    check("col0_deltaDistY", 128'(got0.dy), 128'(16'h0183));
    check("col160_rayDirY", 128'(got160.ry), 0);
    check("col160_deltaDistY", 128'(got160.dy), 128'(16'h7FFF));
    check("busy_forced_seen", 128'(busy_hits > 0), 1);

    // Frame 2: random vectors, busy divider on a random column.
    hold_col = -1;
    busy_col = int'($urandom_range(0, 319));
    run_frame($urandom, $urandom, $urandom, -1, 0);

    // Reset while waiting on the X division, then a stray done.
    busy_col    = -1;
    lat_fixed   = 1000;
    dir_in      = $urandom;
    plane_in    = $urandom;
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.div_start) break;
      @(posedge clk);
      #1;
    end
    check("reset_test_start_seen", 128'(bus.div_start), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_fixed = 0;
    @(posedge clk);
    #2 stray_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_idle", all_outputs(), 0);
    end

    // Frame 4: recovery from reset with a fixed divider latency.
    run_frame($urandom, $urandom, $urandom, -1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
